// File: rtl/sopc_data_bus.sv
// rtl/sopc_data_bus.sv - data-side bus controller: region decode, ack/wait-state handshake, decode-error and timeout reporting
module sopc_data_bus #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int N_SLV        = 4,
    parameter int REGION_SHIFT = 28,
    parameter int TIMEOUT      = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [DATA_W/8-1:0]       cpu_sel,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      cpu_stall,
    output logic                      cpu_err,
    output logic [N_SLV-1:0]          slv_req,
    output logic                      slv_we,
    output logic [DATA_W/8-1:0]       slv_sel,
    output logic [ADDR_W-1:0]         slv_addr,
    output logic [DATA_W-1:0]         slv_wdata,
    input  logic [N_SLV-1:0]          slv_ack,
    input  logic [N_SLV*DATA_W-1:0]   slv_rdata
);
    localparam int SEL_W = DATA_W / 8;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [N_SLV-1:0]    slv_req_q, slv_req_d;
    logic                slv_we_q, slv_we_d;
    logic [SEL_W-1:0]    slv_sel_q, slv_sel_d;
    logic [ADDR_W-1:0]   slv_addr_q, slv_addr_d;
    logic [DATA_W-1:0]   slv_wdata_q, slv_wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_err_q, cpu_err_d;
    logic [7:0]          cnt_q, cnt_d;

    logic [31:0]         rgn_idx;
    logic [N_SLV-1:0]    req_onehot;
    logic [DATA_W-1:0]   ack_rdata;
    logic                ack_hit;

    // Full index field is kept so out-of-range upper bits decode as errors.
    assign rgn_idx = 32'(cpu_addr[ADDR_W-1:REGION_SHIFT]);
    assign ack_hit = |(slv_ack & slv_req_q);

    always_comb begin
        req_onehot = '0;
        ack_rdata  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            req_onehot[i] = (rgn_idx == unsigned'(i));
            if (slv_req_q[i]) begin
                ack_rdata = ack_rdata | slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        slv_req_d   = slv_req_q;
        slv_we_d    = slv_we_q;
        slv_sel_d   = slv_sel_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_err_d   = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    slv_we_d    = cpu_we;
                    slv_sel_d   = cpu_sel;
                    slv_addr_d  = cpu_addr;
                    slv_wdata_d = cpu_wdata;
                    cnt_d       = '0;
                    if (rgn_idx < unsigned'(N_SLV)) begin
                        slv_req_d = req_onehot;
                        state_d   = BUSY;
                    end else begin
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // Ack takes priority over a timeout expiring in the same cycle.
                if (ack_hit) begin
                    cpu_rdata_d = slv_we_q ? '0 : ack_rdata;
                    slv_req_d   = '0;
                    state_d     = RESP;
                end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = '0;
                    slv_req_d   = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                slv_req_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slv_req_q   <= '0;
            slv_we_q    <= 1'b0;
            slv_sel_q   <= '0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            slv_req_q   <= slv_req_d;
            slv_we_q    <= slv_we_d;
            slv_sel_q   <= slv_sel_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_stall = cpu_req & rst_n & (state_q != RESP);
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_err   = cpu_err_q;
    assign slv_req   = slv_req_q;
    assign slv_we    = slv_we_q;
    assign slv_sel   = slv_sel_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;

endmodule

// File: tb/tb_sopc_data_bus.sv
// tb/tb_sopc_data_bus.sv - directed vector bench for sopc_data_bus
module tb_sopc_data_bus;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int N_SLV  = 4;
    localparam logic [N_SLV*DATA_W-1:0] RDATA_BG =
        {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cpu_req = 1'b0;
    logic                    cpu_we = 1'b0;
    logic [DATA_W/8-1:0]     cpu_sel = '0;
    logic [ADDR_W-1:0]       cpu_addr = '0;
    logic [DATA_W-1:0]       cpu_wdata = '0;
    logic [DATA_W-1:0]       cpu_rdata;
    logic                    cpu_stall;
    logic                    cpu_err;
    logic [N_SLV-1:0]        slv_req;
    logic                    slv_we;
    logic [DATA_W/8-1:0]     slv_sel;
    logic [ADDR_W-1:0]       slv_addr;
    logic [DATA_W-1:0]       slv_wdata;
    logic [N_SLV-1:0]        slv_ack = '0;
    logic [N_SLV*DATA_W-1:0] slv_rdata = RDATA_BG;

    int errors = 0;
    int checks = 0;

    sopc_data_bus #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV),
        .REGION_SHIFT(28), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .slv_req(slv_req), .slv_we(slv_we), .slv_sel(slv_sel),
        .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_ack(slv_ack), .slv_rdata(slv_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_slv;
        int          ack_cyc;
        logic [31:0] ack_data;
        int          exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_req;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; cycle 0 is the first cycle with cpu_req high.
    task automatic run_vec(input int n, input vec_t v);
        int resp_c;
        resp_c = -1;
        for (int c = 0; c < 40 && resp_c < 0; c++) begin
            cpu_req   = 1'b1;
            cpu_we    = v.we;
            cpu_sel   = v.sel;
            cpu_addr  = v.addr;
            cpu_wdata = v.wdata;
            slv_rdata = RDATA_BG;
            if (v.ack_slv >= 0) slv_rdata[v.ack_slv*DATA_W +: DATA_W] = v.ack_data;
            slv_ack = (v.ack_slv >= 0 && c == v.ack_cyc) ? 4'(1 << v.ack_slv) : 4'b0;
            @(negedge clk);
            if (c == 1) begin
                chk($sformatf("v%0d_req", n), 64'(slv_req), 64'(v.exp_req));
                chk($sformatf("v%0d_latch", n),
                    {27'b0, slv_we, slv_sel, slv_addr}, {27'b0, v.we, v.sel, v.addr});
                chk($sformatf("v%0d_wdata", n), 64'(slv_wdata), 64'(v.wdata));
            end
            if (!cpu_stall) begin
                resp_c = c;
                chk($sformatf("v%0d_rdata", n), 64'(cpu_rdata), 64'(v.exp_rdata));
                chk($sformatf("v%0d_err", n), 64'(cpu_err), 64'(v.exp_err));
            end
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_resp_cycle", n), 64'(resp_c), 64'(v.exp_resp));
        cpu_req = 1'b0;
        slv_ack = '0;
        @(negedge clk);
        chk($sformatf("v%0d_err_clear", n), 64'(cpu_err), 64'h0);
        chk($sformatf("v%0d_rdata_hold", n), 64'(cpu_rdata), 64'(v.exp_rdata));
        @(posedge clk); #1;
    endtask

    initial begin
        //            we    sel   addr          wdata         slv cyc ack_data      resp rdata         err   req
        vecs[0] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,        0,  1, 32'hDEAD_BEEF, 2,  32'hDEAD_BEEF, 1'b0, 4'b0001};
        vecs[1] = '{1'b1, 4'h3, 32'h2000_0004, 32'h1234_5678, 2,  4, 32'h55AA_55AA, 5,  32'h0,         1'b0, 4'b0100};
        vecs[2] = '{1'b0, 4'hF, 32'h5000_0000, 32'h0,        -1,  0, 32'h0,         1,  32'h0,         1'b1, 4'b0000};
        vecs[3] = '{1'b0, 4'hF, 32'h0000_0040, 32'h0,        0,  1, 32'h7654_3210, 2,  32'h7654_3210, 1'b0, 4'b0001};
        vecs[4] = '{1'b0, 4'hF, 32'h1000_0000, 32'h0,        -1,  0, 32'h0,         16, 32'h0,         1'b1, 4'b0010};
        vecs[5] = '{1'b0, 4'hF, 32'h1000_0020, 32'h0,        1, 15, 32'hCAFE_F00D, 16, 32'hCAFE_F00D, 1'b0, 4'b0010};
        vecs[6] = '{1'b1, 4'h0, 32'h0000_0100, 32'hAAAA_0000, 0,  1, 32'h1357_9BDF, 2,  32'h0,         1'b0, 4'b0001};
        vecs[7] = '{1'b0, 4'hF, 32'h3000_0008, 32'h0,        3,  2, 32'h0BAD_F00D, 3,  32'h0BAD_F00D, 1'b0, 4'b1000};

        cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_stall", 64'(cpu_stall), 64'h0);
        chk("rst_req", 64'(slv_req), 64'h0);
        chk("rst_outs", {31'b0, cpu_err, cpu_rdata}, 64'h0);
        chk("rst_slv", {slv_addr, slv_wdata}, 64'h0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Ack while idle must be ignored.
        slv_ack = 4'b0001;
        slv_rdata = RDATA_BG;
        @(negedge clk);
        chk("idle_ack_req", 64'(slv_req), 64'h0);
        @(posedge clk); #1;
        slv_ack = '0;
        @(negedge clk);
        chk("idle_ack_rdata", 64'(cpu_rdata), 64'h0BAD_F00D);
        @(posedge clk); #1;

        // Foreign ack, changed CPU fields during BUSY, ack during RESP.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_addr = 32'h0000_0020;
        @(posedge clk); #1;
        slv_ack = 4'b1000;
        slv_rdata[3*DATA_W +: DATA_W] = 32'h9999_9999;
        @(negedge clk);
        chk("foreign_stall", 64'(cpu_stall), 64'h1);
        @(posedge clk); #1;
        slv_ack = '0; cpu_addr = 32'h3000_0000;
        @(negedge clk);
        chk("foreign_req", 64'(slv_req), 64'h1);
        chk("busy_addr_held", 64'(slv_addr), 64'h20);
        @(posedge clk); #1;
        slv_ack = 4'b0001; cpu_addr = 32'h0000_0020;
        slv_rdata[0 +: DATA_W] = 32'h1111_2222;
        @(negedge clk);
        chk("foreign_busy_c3", 64'(cpu_stall), 64'h1);
        @(posedge clk); #1;
        slv_ack = 4'b0001;
        slv_rdata[0 +: DATA_W] = 32'h7777_7777;
        @(negedge clk);
        chk("foreign_resp", {31'b0, cpu_stall, cpu_rdata}, 64'h1111_2222);
        @(posedge clk); #1;
        cpu_req = 1'b0; slv_ack = '0;
        @(negedge clk);
        chk("resp_ack_ignored", {28'b0, slv_req, cpu_rdata}, 64'h1111_2222);
        @(posedge clk); #1;

        // Request dropped during BUSY still completes.
        cpu_req = 1'b1; cpu_addr = 32'h2000_0000;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("drop_busy_req", {31'b0, cpu_stall, 28'b0, slv_req}, 64'h4);
        @(posedge clk); #1;
        slv_ack = 4'b0100;
        slv_rdata[2*DATA_W +: DATA_W] = 32'h2468_ACE0;
        @(posedge clk); #1;
        slv_ack = '0;
        @(negedge clk);
        chk("drop_resp", {28'b0, slv_req, cpu_rdata}, 64'h2468_ACE0);
        @(posedge clk); #1;

        // Reset asserted mid-BUSY.
        cpu_req = 1'b1; cpu_addr = 32'h1000_0000;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rstbusy_pre", 64'(slv_req), 64'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("rstbusy_req", 64'(slv_req), 64'h0);
        chk("rstbusy_outs", {31'b0, cpu_stall, cpu_rdata}, 64'h0);
        chk("rstbusy_addr", 64'(slv_addr), 64'h0);
        repeat (2) @(posedge clk);
        #1 cpu_req = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstbusy_noreplay", {28'b0, slv_req, slv_addr}, 64'h0);
        @(posedge clk); #1;
        run_vec(8, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sopc_data_bus.md
Name: sopc_data_bus

Overview:
Parametrised data-side bus controller between the CPU load/store port and N_SLV memory-mapped slaves (data RAM, peripherals). It decodes the address into a slave region and forwards the access. It supports variable slave wait states through an ack handshake and stalls the CPU until completion. It flags decode errors and timeouts, replacing the fixed single-cycle, single-RAM data path of the minimal SoC top.

Parameters:
ADDR_W, 32, CPU data address width
DATA_W, 32, data width; must be a multiple of 8
N_SLV, 4, number of slave regions (1..16)
REGION_SHIFT, 28, region index = cpu_addr[ADDR_W-1:REGION_SHIFT]
TIMEOUT, 15, BUSY cycles without ack before error (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request (ram_en equivalent)
cpu_we  in  1  1 = write, 0 = read
cpu_sel  in  DATA_W/8  byte-lane enables
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid in RESP cycle only
cpu_stall  out  1  hold CPU pipeline
cpu_err  out  1  access failed, valid in RESP cycle only
slv_req  out  N_SLV  one-hot request to the selected slave
slv_we  out  1  latched write enable
slv_sel  out  DATA_W/8  latched byte enables
slv_addr  out  ADDR_W  latched address
slv_wdata  out  DATA_W  latched write data
slv_ack  in  N_SLV  per-slave completion, 1-cycle pulse
slv_rdata  in  N_SLV*DATA_W  slave i read data on bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (async, rst_n=0): state IDLE; slv_req=0; slv_we=0; slv_sel=0; slv_addr=0; slv_wdata=0; cpu_rdata=0; cpu_err=0; timeout counter=0. cpu_stall=0 while rst_n=0.
- States: IDLE, BUSY, RESP.
- IDLE with cpu_req=1:
  - Latch we/sel/addr/wdata into the slv_* registers.
  - Region index < N_SLV: next state BUSY, slv_req[idx] set at the same edge, counter cleared.
  - Region index >= N_SLV (decode error): next state RESP with cpu_err=1 and cpu_rdata=0. No slave is requested.
- BUSY:
  - slv_req held one-hot. Counter increments each cycle.
  - slv_ack[idx]=1: capture slv_rdata of idx into cpu_rdata (writes capture 0), cpu_err=0, clear slv_req, go RESP.
  - Counter reaches TIMEOUT with no ack: clear slv_req, cpu_err=1, cpu_rdata=0, go RESP.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP: lasts exactly one cycle. cpu_rdata and cpu_err are valid. Then go to IDLE. cpu_rdata holds its value afterwards; cpu_err clears to 0 on leaving RESP.
- cpu_stall is combinational: cpu_req & (state != RESP). The CPU advances only in the RESP cycle. A back-to-back request is accepted in the IDLE cycle after RESP.
- Latency: cpu_req rises in cycle 0, a slave acking in its first BUSY cycle gives RESP at cycle 2. Each wait state adds 1 cycle. A decode error gives RESP at cycle 1.
- The CPU holds request fields while stalled. The block uses only the latched copies, so changes to cpu_* during BUSY are ignored.
- Acks from non-selected slaves, and any ack in IDLE or RESP, are ignored.
- cpu_req dropping during BUSY does not abort: the transaction completes and RESP occurs with cpu_stall=0.
- Write with cpu_sel=0 is forwarded unchanged; byte-lane interpretation is the slave's job.
- Reset asserted mid-BUSY: slv_req drops immediately (async). The latched transaction is discarded and not replayed after reset.
- Width rules: the region index field width is ADDR_W-REGION_SHIFT. Widths beyond N_SLV encoding are decoded as errors, not truncated.

Test Plan:
- Read, zero wait: cpu_addr=0x0000_0010, slave 0 acks in first BUSY cycle with 0xDEADBEEF -> slv_req=4'b0001 for 1 cycle; RESP at cycle 2 with cpu_rdata=0xDEADBEEF, cpu_err=0; cpu_stall high cycles 0-1.
- Write, 3 wait states: cpu_addr=0x2000_0004, cpu_sel=4'b0011, cpu_wdata=0x1234_5678; slave 2 acks on the 4th BUSY cycle -> slv_req=4'b0100 for 4 cycles; slv_* match the inputs; RESP at cycle 5, cpu_err=0.
- Decode error: cpu_addr=0x5000_0000 with N_SLV=4 -> no slv_req bit set; RESP at cycle 1, cpu_err=1, cpu_rdata=0.
- Timeout: slave 1 never acks, TIMEOUT=15 -> slv_req[1] high 15 cycles; RESP with cpu_err=1, cpu_rdata=0. Ack on cycle 15 together with counter=TIMEOUT -> no error.
- Spurious/foreign ack: slave 3 pulses slv_ack while slave 0 is selected, and slave 0 pulses in IDLE -> no state change; transaction completes only on slv_ack[0].
- Reset mid-BUSY: rst_n low two cycles into a slave-1 read -> slv_req=0 and all outputs at reset values immediately; after release, IDLE with no replayed request.
